// File: rtl/core_port_arb.sv
// rtl/core_port_arb.sv - two-requester arbiter onto a single shared core memory port
//
// Purpose:
//   Arbitrates two core-side requesters (m0, m1) onto one shared request port.
//   Only one transaction may be outstanding at a time. A new request can be
//   issued in the same cycle as the outstanding response, so the arbiter adds
//   no cycles to the shared port's grant-to-response latency. Contested
//   requests alternate round-robin. A requester that is waiting for a grant
//   keeps its selection until that grant arrives.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mN_req_i / mN_gnt_o           requester N handshake (gnt is combinational)
//   mN_addr_i/we_i/be_i/wdata_i   requester N request fields
//   mN_rvalid_o / mN_rdata_o      requester N response
//   s_req_o / s_gnt_i             shared-port handshake
//   s_addr_o/we_o/be_o/wdata_o    forwarded request fields of the selected requester
//   s_rvalid_i / s_rdata_i        shared-port response
//   unexp_rvalid_o                sticky: response seen with nothing outstanding

module core_port_arb #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic [31:0]           m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic [31:0]           m1_rdata_o,

    output logic                  s_req_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [31:0]           s_wdata_o,
    input  logic [31:0]           s_rdata_i,

    output logic                  unexp_rvalid_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t r_state;
    logic   r_lock;
    logic   r_lock_id;
    logic   r_owner;
    logic   r_prio;
    logic   r_unexp;

    logic   w_issue_en;
    logic   w_sel;
    logic   w_sel_req;
    logic   w_grant;
    logic   w_rsp;

    // A response frees the single outstanding slot in the same cycle, so a
    // new request may go out alongside it.
    assign w_issue_en = (r_state == IDLE) || ((r_state == WAIT) && s_rvalid_i);
    assign w_rsp      = (r_state == WAIT) && s_rvalid_i;

    // Selection: a pending (ungranted) request is locked so that the request
    // fields presented to the shared port never change before its grant.
    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_lock_id;
        end else if (m0_req_i && m1_req_i) begin
            w_sel = r_prio;
        end else if (m1_req_i) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_req = w_sel ? m1_req_i : m0_req_i;

    // Gated by reset so the handshake outputs are quiet while rst_ni is low.
    assign s_req_o   = rst_ni && w_issue_en && w_sel_req;
    assign w_grant   = s_req_o && s_gnt_i;

    assign s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = w_sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = w_sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o  = w_grant && !w_sel;
    assign m1_gnt_o  = w_grant &&  w_sel;

    assign m0_rvalid_o = rst_ni && w_rsp && !r_owner;
    assign m1_rvalid_o = rst_ni && w_rsp &&  r_owner;

    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign unexp_rvalid_o = r_unexp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_owner   <= 1'b0;
            r_prio    <= 1'b0;
            r_unexp   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && s_rvalid_i) begin
                r_unexp <= 1'b1;
            end

            if (w_grant) begin
                r_lock  <= 1'b0;
                r_owner <= w_sel;
                r_prio  <= ~w_sel;
                r_state <= WAIT;
            end else begin
                if (s_req_o) begin
                    r_lock    <= 1'b1;
                    r_lock_id <= w_sel;
                end else if (r_lock && !w_sel_req) begin
                    // Locked requester withdrew before its grant: drop the
                    // lock and arbitrate afresh next cycle.
                    r_lock <= 1'b0;
                end
                if (w_rsp) begin
                    r_state <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/core_port_arb.md
CORE_PORT_ARB -- requirements
Module: core_port_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req_i/m1_req_i  input  1  requester N request, held until granted.
REQ-005 SHALL have ports m0_gnt_o/m1_gnt_o  output  1  requester N request accepted this cycle.
REQ-006 SHALL have ports m0_rvalid_o/m1_rvalid_o  output  1  requester N response valid.
REQ-007 SHALL have ports m0_addr_i/m1_addr_i  input  ADDR_WIDTH  requester N address.
REQ-008 SHALL have ports m0_we_i/m1_we_i  input  1  requester N write enable.
REQ-009 SHALL have ports m0_be_i/m1_be_i  input  4  requester N byte enables.
REQ-010 SHALL have ports m0_wdata_i/m1_wdata_i  input  32  requester N write data.
REQ-011 SHALL have ports m0_rdata_o/m1_rdata_o  output  32  response data.
REQ-012 SHALL have port s_req_o  output  1  shared-port request.
REQ-013 SHALL have port s_gnt_i  input  1  shared-port grant, may be combinational on s_req_o.
REQ-014 SHALL have port s_rvalid_i  input  1  shared-port response, at least 1 cycle after its grant.
REQ-015 SHALL have ports s_addr_o (ADDR_WIDTH), s_we_o (1), s_be_o (4), s_wdata_o (32)  output  forwarded request fields.
REQ-016 SHALL have port s_rdata_i  input  32  shared-port response data.
REQ-017 SHALL have port unexp_rvalid_o  output  1  sticky flag: s_rvalid_i seen with nothing outstanding.

Function
REQ-018 SHALL implement states IDLE (nothing outstanding) and WAIT (one transaction outstanding, owner in owner_q).
REQ-019 SHALL enable issue when state==IDLE, or state==WAIT and s_rvalid_i==1.
REQ-020 SHALL select: lock_q==1 -> lock_id_q; else both requesting -> prio_q; else the single requester; else none.
REQ-021 SHALL drive s_req_o = issue enabled AND selected requester's req; s_addr_o/s_we_o/s_be_o/s_wdata_o = selected requester's fields (requester 0 fields when none).
REQ-022 SHALL drive mN_gnt_o = s_req_o AND s_gnt_i AND selected==N, combinationally, same cycle.
REQ-023 SHALL on s_req_o==1 and s_gnt_i==0 set lock_q=1, lock_id_q=selected, so selection never switches before grant.
REQ-024 SHALL on grant clear lock_q, set owner_q=selected, set prio_q=other requester, enter WAIT.
REQ-025 SHALL in WAIT with s_rvalid_i==1 pulse m<owner_q>_rvalid_o for that cycle only, other rvalid 0; return to IDLE unless a new grant occurs that cycle (then stay WAIT with new owner).
REQ-026 SHALL drive m0_rdata_o and m1_rdata_o = s_rdata_i unconditionally.
REQ-027 SHALL clear lock_q if the locked requester deasserts req (protocol violation); s_req_o 0 that cycle; re-arbitrate next cycle.
REQ-028 SHALL in IDLE ignore s_rvalid_i (no mN_rvalid_o) and set unexp_rvalid_o, held until reset.
REQ-029 SHALL allow at most one outstanding transaction; grant-to-rvalid latency adds zero cycles over the shared port.

Reset
REQ-030 SHALL on rst_ni==0 immediately set state IDLE, lock_q 0, lock_id_q 0, owner_q 0, prio_q 0 (requester 0 first), unexp_rvalid_o 0; all gnt/rvalid outputs and s_req_o 0.
REQ-031 SHALL discard any outstanding transaction on reset; a subsequent s_rvalid_i sets unexp_rvalid_o.

Verification
REQ-032 Both req same cycle after reset, s_gnt_i=1 -> m0_gnt_o=1; next transaction contested -> m1 granted (alternation).
REQ-033 m1 req, s_gnt_i=0 for 3 cycles, m0 req asserted cycle 2 -> s_addr_o stays m1_addr_i, m1_gnt_o on cycle 4 grant only.
REQ-034 m0 read granted, s_rvalid_i 2 cycles later with s_rdata_i=0xDEADBEEF -> m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m1_rvalid_o=0.
REQ-035 s_rvalid_i and m1 req same cycle, s_gnt_i=1 -> m0_rvalid_o=1, m1_gnt_o=1, state stays WAIT with owner 1.
REQ-036 s_rvalid_i=1 in IDLE -> no mN_rvalid_o, unexp_rvalid_o=1 until rst_ni low.
REQ-037 rst_ni low in WAIT, released, then s_rvalid_i -> no rvalid to requesters, unexp_rvalid_o=1.
